prng_io_module: RTL and testbench

//  - Pseudo-random number generator peripheral on the MicroBlaze MCS IO bus.
//  - Slave-only. Decodes a 12-bit offset and exposes two 32-bit registers: SEED and RAND.
//  - The generator is a 32-bit xorshift (shifts 13, 17, 5).
//  - Software reseeds through SEED and pulls values by reading RAND.

---
 rtl/prng_io_module.sv | 101 ++++++++++
 tb/tb_prng_io_module.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_io_module.sv
// 32-bit xorshift (13/17/5) PRNG slave on the MicroBlaze MCS IO bus: SEED at 0x000, RAND at 0x004.
// Optional build macro PRNG_FREERUN_EN: the state also steps on every clock cycle.
module prng_io_module #(
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [11:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready
);

  localparam logic [9:0] WORD_SEED = 10'd0;
  localparam logic [9:0] WORD_RAND = 10'd1;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  // An all-zero state would lock xorshift at zero forever.
  function automatic logic [31:0] nonzero_seed(input logic [31:0] v);
    return (v == 32'h0) ? DEFAULT_SEED : v;
  endfunction

  logic [31:0] seed_q,  seed_d;
  logic [31:0] state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  logic       wr_acc;
  logic       rd_acc;
  logic [9:0] word;

  assign word   = io_address[11:2];
  assign wr_acc = io_addr_strobe & io_write_strobe;
  // A combined read+write strobe is treated as a write only.
  assign rd_acc = io_addr_strobe & io_read_strobe & ~io_write_strobe;

  always_comb begin
    seed_d  = seed_q;
    rdata_d = 32'h0;
    ready_d = io_addr_strobe;
`ifdef PRNG_FREERUN_EN
    state_d = xorshift32(state_q);
`else
    state_d = state_q;
`endif
    if (wr_acc) begin
      if (word == WORD_SEED) begin
        seed_d  = nonzero_seed(merge_lanes(seed_q, io_write_data, io_byte_enable));
        // Loading overrides any free-run step in the same cycle.
        state_d = seed_d;
      end
    end else if (rd_acc) begin
      case (word)
        WORD_SEED: rdata_d = seed_q;
        WORD_RAND: begin
          state_d = xorshift32(state_d);
          rdata_d = state_d;
        end
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q  <= DEFAULT_SEED;
      state_q <= DEFAULT_SEED;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      seed_q  <= seed_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign io_read_data = rdata_q;
  assign io_ready     = ready_q;

endmodule

// File: tb/tb_prng_io_module.sv
// Self-checking bench for prng_io_module (default build): directed vectors plus random bus traffic vs a model.
module tb_prng_io_module;

  logic        clk;
  logic        rst;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [11:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the registers as software sees them.
  logic [31:0] m_seed;
  logic [31:0] m_state;
  logic [31:0] seq_a [4];

  prng_io_module dut (
    .clk             (clk),
    .rst             (rst),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_address      (io_address),
    .io_byte_enable  (io_byte_enable),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Model of one accepted access; returns the read data software should see.
  function automatic logic [31:0] model_access(input logic rd, input logic wr,
                                               input logic [11:0] addr, input logic [3:0] be,
                                               input logic [31:0] wd);
    logic [31:0] merged;
    int unsigned w;
    w = addr / 4;
    if (wr) begin
      if (w == 0) begin
        merged = m_seed;
        for (int b = 0; b < 4; b++)
          if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
        if (merged == 0) merged = 32'h1;
        m_seed  = merged;
        m_state = merged;
      end
      return 32'h0;
    end
    if (rd) begin
      if (w == 0) return m_seed;
      if (w == 1) begin
        m_state = ref_step(m_state);
        return m_state;
      end
    end
    return 32'h0;
  endfunction

  task automatic idle_bus();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_address      = 12'h0;
    io_byte_enable  = 4'h0;
    io_write_data   = 32'h0;
  endtask

  // One access followed by one idle cycle; returns the observed read data.
  task automatic bus_xfer(input string tag, input logic rd, input logic wr,
                          input logic [11:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] exp;
    @(negedge clk);
    chk({tag, ".pre_ready"}, {31'h0, io_ready}, 32'h0);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_address      = addr;
    io_byte_enable  = be;
    io_write_data   = wd;
    exp = model_access(rd, wr, addr, be, wd);
    @(posedge clk); #1;
    chk({tag, ".ready"}, {31'h0, io_ready}, 32'h1);
    chk({tag, ".data"}, io_read_data, exp);
    got = io_read_data;
    @(negedge clk);
    idle_bus();
    @(posedge clk); #1;
    chk({tag, ".ready_drop"}, {31'h0, io_ready}, 32'h0);
    chk({tag, ".data_idle"}, io_read_data, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b0;
    idle_bus();
    m_seed  = 32'h1;
    m_state = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", {31'h0, io_ready}, 32'h0);
    chk("reset.data", io_read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    bus_xfer("seed_rst", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_rst.const", r, 32'h0000_0001);
    bus_xfer("rand_rst", 1, 0, 12'h004, 4'h0, 32'h0, r);
    chk("rand_rst.const", r, 32'h0004_2021);

    bus_xfer("wr_zero", 0, 1, 12'h000, 4'hF, 32'h0, r);
    bus_xfer("seed_zero", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_zero.const", r, 32'h0000_0001);
    bus_xfer("rand_zero", 1, 0, 12'h004, 4'h0, 32'h0, r);
    chk("rand_zero.const", r, 32'h0004_2021);

    bus_xfer("wr_dead", 0, 1, 12'h000, 4'hF, 32'hDEAD_BEEF, r);
    bus_xfer("seed_dead", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_dead.const", r, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      bus_xfer("seq_a", 1, 0, 12'h004, 4'h0, 32'h0, r);
      seq_a[i] = r;
    end
    chk("seq_a0.const", seq_a[0], 32'h477D_20B7);
    bus_xfer("wr_dead2", 0, 1, 12'h000, 4'hF, 32'hDEAD_BEEF, r);
    for (int i = 0; i < 4; i++) begin
      bus_xfer("seq_b", 1, 0, 12'h004, 4'h0, 32'h0, r);
      chk("seq_b.repeat", r, seq_a[i]);
    end

    bus_xfer("rd_unmapped", 1, 0, 12'h008, 4'h0, 32'h0, r);
    bus_xfer("wr_unmapped", 0, 1, 12'h008, 4'hF, 32'h1234_5678, r);
    bus_xfer("seed_after_unmapped", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_after_unmapped.const", r, 32'hDEAD_BEEF);
    bus_xfer("wr_rand_ro", 0, 1, 12'h004, 4'hF, 32'hCAFE_F00D, r);
    bus_xfer("seed_after_ro", 1, 0, 12'h000, 4'h0, 32'h0, r);

    bus_xfer("wr_be", 0, 1, 12'h000, 4'b0001, 32'h1122_3344, r);
    bus_xfer("seed_be", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_be.const", r, 32'hDEAD_BE44);

    bus_xfer("rdwr_both", 1, 1, 12'h000, 4'hF, 32'h0BAD_F00D, r);
    bus_xfer("seed_both", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_both.const", r, 32'h0BAD_F00D);

    // Back-to-back RAND reads on consecutive cycles.
    @(negedge clk);
    io_addr_strobe = 1'b1;
    io_read_strobe = 1'b1;
    io_address     = 12'h004;
    for (int i = 0; i < 3; i++) begin
      r = model_access(1, 0, 12'h004, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("b2b.ready", {31'h0, io_ready}, 32'h1);
      chk("b2b.data", io_read_data, r);
      @(negedge clk);
    end
    idle_bus();
    @(posedge clk); #1;
    chk("b2b.ready_drop", {31'h0, io_ready}, 32'h0);

    // Reset lands after the strobe is issued but before it can be acknowledged.
    @(negedge clk);
    io_addr_strobe  = 1'b1;
    io_write_strobe = 1'b1;
    io_address      = 12'h000;
    io_byte_enable  = 4'hF;
    io_write_data   = 32'h0000_0055;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.ready", {31'h0, io_ready}, 32'h0);
    chk("rst_mid.data", io_read_data, 32'h0);
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    m_seed  = 32'h1;
    m_state = 32'h1;
    @(posedge clk); #1;
    chk("rst_mid.ready_after", {31'h0, io_ready}, 32'h0);
    bus_xfer("seed_rst_mid", 1, 0, 12'h000, 4'h0, 32'h0, r);
    chk("seed_rst_mid.const", r, 32'h0000_0001);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      logic [11:0] a;
      op = $urandom_range(0, 7);
      a  = {10'h0, 2'($urandom_range(0, 3))};
      case (op)
        0, 1: bus_xfer("rnd_rand", 1, 0, a | 12'h004, 4'h0, $urandom, r);
        2:    bus_xfer("rnd_seed", 1, 0, a, 4'h0, $urandom, r);
        3:    bus_xfer("rnd_wseed", 0, 1, a, 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, r);
        4:    bus_xfer("rnd_other", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       12'($urandom_range(2, 1023) * 4) | a, 4'hF, $urandom, r);
        5:    bus_xfer("rnd_both", 1, 1, a | 12'(4 * $urandom_range(0, 1)), 4'hF, $urandom, r);
        default: begin
          // Strobes without io_addr_strobe must be ignored.
          @(negedge clk);
          io_read_strobe  = 1'($urandom_range(0, 1));
          io_write_strobe = 1'($urandom_range(0, 1));
          io_address      = 12'h000;
          io_byte_enable  = 4'hF;
          io_write_data   = $urandom;
          @(posedge clk); #1;
          chk("rnd_noaddr.ready", {31'h0, io_ready}, 32'h0);
          @(negedge clk);
          idle_bus();
        end
      endcase
    end
    bus_xfer("final_seed", 1, 0, 12'h000, 4'h0, 32'h0, r);
    bus_xfer("final_rand", 1, 0, 12'h004, 4'h0, 32'h0, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
